// File: rtl/alu.sv
// 16-bit CR16 integer ALU: combinational result/flag generation followed by a
// single enabled register stage for the result and the PSR-style status vector.
module alu (
    input  logic        I_CLK,
    input  logic        I_NRESET,
    input  logic        I_ENABLE,
    input  logic [15:0] I_A,
    input  logic [15:0] I_B,
    input  logic [3:0]  I_OPCODE,
    output logic [15:0] O_C,
    output logic [4:0]  O_STATUS
);

    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_MUL  = 4'd2,
        OP_SUB  = 4'd3,
        OP_NOT  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_LSH  = 4'd8,
        OP_RSH  = 4'd9,
        OP_ALSH = 4'd10,
        OP_ARSH = 4'd11
    } opcode_t;

    // Any amount of 16 or more empties the word; arithmetic right shifts fill with the sign.
    function automatic logic [DATA_W-1:0] shift_op(
        input logic [DATA_W-1:0] val,
        input logic [DATA_W-1:0] amt,
        input logic              left,
        input logic              arith
    );
        logic signed [DATA_W-1:0] val_s;
        logic                     too_far;
        val_s   = val;
        too_far = |amt[DATA_W-1:4];
        if (too_far)
            shift_op = (arith && val[DATA_W-1]) ? '1 : '0;
        else if (left)
            shift_op = val << amt[3:0];
        else if (arith)
            shift_op = val_s >>> amt[3:0];
        else
            shift_op = val >> amt[3:0];
    endfunction

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] mul_lo;
    logic        [DATA_W-1:0] res_p0;
    logic                     flag_f_p0;
    logic                     flag_n_p0;
    logic                     flag_z_p0;
    logic        [DATA_W-1:0] c_p1;
    logic        [4:0]        status_p1;

    assign a_s    = I_A;
    assign b_s    = I_B;
    // The low half of a product is the same for signed and unsigned operands.
    assign mul_lo = a_s * b_s;

    // Stage p0: combinational result and flags
    always_comb begin
        res_p0    = '0;
        flag_f_p0 = 1'b0;
        flag_n_p0 = 1'b0;
        flag_z_p0 = 1'b0;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                res_p0    = I_A + I_B + ((I_OPCODE == OP_ADDC) ? 16'd1 : 16'd0);
                flag_f_p0 = (I_A[15] == I_B[15]) && (res_p0[15] != I_A[15]);
                flag_n_p0 = res_p0[15];
            end
            OP_SUB: begin
                res_p0    = I_B - I_A;
                flag_f_p0 = (I_A[15] != I_B[15]) && (res_p0[15] != I_B[15]);
                flag_n_p0 = b_s < a_s;
            end
            OP_MUL:  res_p0 = mul_lo;
            OP_NOT:  res_p0 = ~I_A;
            OP_AND:  res_p0 = I_A & I_B;
            OP_OR:   res_p0 = I_A | I_B;
            OP_XOR:  res_p0 = I_A ^ I_B;
            OP_LSH, OP_ALSH: res_p0 = shift_op(I_A, I_B, 1'b1, 1'b0);
            OP_RSH:  res_p0 = shift_op(I_A, I_B, 1'b0, 1'b0);
            OP_ARSH: res_p0 = shift_op(I_A, I_B, 1'b0, 1'b1);
            default: res_p0 = '0;
        endcase
        if (I_OPCODE <= OP_ARSH) begin
            flag_z_p0 = (res_p0 == '0);
            if (I_OPCODE != OP_ADD && I_OPCODE != OP_ADDC && I_OPCODE != OP_SUB)
                flag_n_p0 = res_p0[15];
        end
    end

    // Stage p1: enabled result/status register; C and L are reserved zeros
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            c_p1      <= '0;
            status_p1 <= '0;
        end else if (I_ENABLE) begin
            c_p1      <= res_p0;
            status_p1 <= {flag_n_p0, flag_z_p0, flag_f_p0, 1'b0, 1'b0};
        end
    end

    assign O_C      = c_p1;
    assign O_STATUS = status_p1;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the CR16 ALU; status packing is {N,Z,F,L,C}.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] c;
    logic [4:0]  st;

    int n_cmp = 0;
    int n_bad = 0;

    alu dut (
        .I_CLK    (clk),
        .I_NRESET (rst_n),
        .I_ENABLE (en),
        .I_A      (a),
        .I_B      (b),
        .I_OPCODE (op),
        .O_C      (c),
        .O_STATUS (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv);
        op = o;
        a  = av;
        b  = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        a     = 16'h1234;
        b     = 16'h1111;
        op    = 4'd0;
        #2;
        n_cmp++;
        if ({st, c} !== 21'h0) begin
            n_bad++;
            $display("FAIL reset_init: got c=%h st=%b, want c=0000 st=00000", c, st);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({st, c} !== 21'h0) begin
            n_bad++;
            $display("FAIL reset_held_edge: got c=%h st=%b, want c=0000 st=00000", c, st);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add;
        apply(4'd0, 16'h7C00, 16'h0400);
        n_cmp++;
        if (c !== 16'h8000 || st !== 5'b10100) begin
            n_bad++;
            $display("FAIL add_ovf: got c=%h st=%b, want c=8000 st=10100", c, st);
        end
        apply(4'd0, 16'h8000, 16'h8000);
        n_cmp++;
        if (c !== 16'h0000 || st !== 5'b01100) begin
            n_bad++;
            $display("FAIL add_wrap_zero: got c=%h st=%b, want c=0000 st=01100", c, st);
        end
        apply(4'd1, 16'hFC00, 16'h0400);
        n_cmp++;
        if (c !== 16'h0001 || st !== 5'b00000) begin
            n_bad++;
            $display("FAIL addc: got c=%h st=%b, want c=0001 st=00000", c, st);
        end
    endtask

    task automatic test_sub;
        apply(4'd3, 16'h0400, 16'h0400);
        n_cmp++;
        if (c !== 16'h0000 || st !== 5'b01000) begin
            n_bad++;
            $display("FAIL sub_eq: got c=%h st=%b, want c=0000 st=01000", c, st);
        end
        apply(4'd3, 16'h0400, 16'h8000);
        n_cmp++;
        if (c !== 16'h7C00 || st !== 5'b10100) begin
            n_bad++;
            $display("FAIL sub_ovf_lt: got c=%h st=%b, want c=7c00 st=10100", c, st);
        end
        apply(4'd3, 16'h8000, 16'h0000);
        n_cmp++;
        if (c !== 16'h8000 || st !== 5'b00100) begin
            n_bad++;
            $display("FAIL sub_ovf_gt: got c=%h st=%b, want c=8000 st=00100", c, st);
        end
        apply(4'd3, 16'h0005, 16'h0003);
        n_cmp++;
        if (c !== 16'hFFFE || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL sub_neg: got c=%h st=%b, want c=fffe st=10000", c, st);
        end
    endtask

    task automatic test_mul_logic;
        apply(4'd2, 16'hFC00, 16'h0400);
        n_cmp++;
        if (c !== 16'h0000 || st !== 5'b01000) begin
            n_bad++;
            $display("FAIL mul_trunc: got c=%h st=%b, want c=0000 st=01000", c, st);
        end
        apply(4'd2, 16'hFFFD, 16'h0007);
        n_cmp++;
        if (c !== 16'hFFEB || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL mul_neg: got c=%h st=%b, want c=ffeb st=10000", c, st);
        end
        apply(4'd5, 16'hF0F0, 16'h0FF0);
        n_cmp++;
        if (c !== 16'h00F0 || st !== 5'b00000) begin
            n_bad++;
            $display("FAIL and: got c=%h st=%b, want c=00f0 st=00000", c, st);
        end
        apply(4'd4, 16'h0400, 16'hAAAA);
        n_cmp++;
        if (c !== 16'hFBFF || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL not: got c=%h st=%b, want c=fbff st=10000", c, st);
        end
        apply(4'd6, 16'hF000, 16'h000F);
        n_cmp++;
        if (c !== 16'hF00F || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL or: got c=%h st=%b, want c=f00f st=10000", c, st);
        end
        apply(4'd7, 16'h5A5A, 16'h5A5A);
        n_cmp++;
        if (c !== 16'h0000 || st !== 5'b01000) begin
            n_bad++;
            $display("FAIL xor_zero: got c=%h st=%b, want c=0000 st=01000", c, st);
        end
    endtask

    task automatic test_shift;
        apply(4'd8, 16'h0001, 16'd4);
        n_cmp++;
        if (c !== 16'h0010 || st !== 5'b00000) begin
            n_bad++;
            $display("FAIL lsh4: got c=%h st=%b, want c=0010 st=00000", c, st);
        end
        apply(4'd9, 16'h8000, 16'd15);
        n_cmp++;
        if (c !== 16'h0001 || st !== 5'b00000) begin
            n_bad++;
            $display("FAIL rsh15: got c=%h st=%b, want c=0001 st=00000", c, st);
        end
        apply(4'd11, 16'h8000, 16'd4);
        n_cmp++;
        if (c !== 16'hF800 || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL arsh4: got c=%h st=%b, want c=f800 st=10000", c, st);
        end
        apply(4'd11, 16'h8000, 16'h0400);
        n_cmp++;
        if (c !== 16'hFFFF || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL arsh_big: got c=%h st=%b, want c=ffff st=10000", c, st);
        end
        apply(4'd11, 16'h7000, 16'd16);
        n_cmp++;
        if (c !== 16'h0000 || st !== 5'b01000) begin
            n_bad++;
            $display("FAIL arsh_big_pos: got c=%h st=%b, want c=0000 st=01000", c, st);
        end
        apply(4'd8, 16'h1234, 16'h0400);
        n_cmp++;
        if (c !== 16'h0000 || st !== 5'b01000) begin
            n_bad++;
            $display("FAIL lsh_big: got c=%h st=%b, want c=0000 st=01000", c, st);
        end
        apply(4'd10, 16'h0003, 16'd14);
        n_cmp++;
        if (c !== 16'hC000 || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL alsh14: got c=%h st=%b, want c=c000 st=10000", c, st);
        end
        apply(4'd9, 16'hABCD, 16'd0);
        n_cmp++;
        if (c !== 16'hABCD || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL rsh0: got c=%h st=%b, want c=abcd st=10000", c, st);
        end
    endtask

    task automatic test_undefined_op;
        apply(4'd0, 16'h7C00, 16'h0400);
        apply(4'd13, 16'h1234, 16'h5678);
        n_cmp++;
        if (c !== 16'h0000 || st !== 5'b00000) begin
            n_bad++;
            $display("FAIL op13: got c=%h st=%b, want c=0000 st=00000", c, st);
        end
    endtask

    task automatic test_enable_hold;
        apply(4'd0, 16'h0001, 16'h0001);
        en = 1'b0;
        apply(4'd3, 16'h0001, 16'h8000);
        apply(4'd4, 16'h0000, 16'h0000);
        n_cmp++;
        if (c !== 16'h0002 || st !== 5'b00000) begin
            n_bad++;
            $display("FAIL enable_hold: got c=%h st=%b, want c=0002 st=00000", c, st);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (c !== 16'hFFFF || st !== 5'b10000) begin
            n_bad++;
            $display("FAIL enable_resume: got c=%h st=%b, want c=ffff st=10000", c, st);
        end
    endtask

    task automatic test_async_reset;
        apply(4'd11, 16'h8000, 16'd15);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({st, c} !== 21'h0) begin
            n_bad++;
            $display("FAIL async_reset: got c=%h st=%b, want c=0000 st=00000", c, st);
        end
        #3;
        rst_n = 1'b1;
        apply(4'd0, 16'h0010, 16'h0020);
        n_cmp++;
        if (c !== 16'h0030 || st !== 5'b00000) begin
            n_bad++;
            $display("FAIL after_reset: got c=%h st=%b, want c=0030 st=00000", c, st);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul_logic();
        test_shift();
        test_undefined_op();
        test_enable_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
